seq_divider: RTL and testbench

//  Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. Sits in EX beside the ALU.

---
 rtl/riscv_div_pkg.sv | 16 +
 rtl/div_step.sv | 23 ++
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// divide-by-zero quotient constant.
package riscv_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // Wide enough for any supported WIDTH; the top slices off what it needs.
    localparam int unsigned DIV0_MAX_WIDTH = 64;
    localparam logic [DIV0_MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, try the
// subtraction, keep it only when the partial remainder stays non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor, so the shifted value stays below 2*divisor and the
    // top bit of the WIDTH+1 bit difference is a reliable sign bit.
    assign shifted = {rem_in, next_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient
// bit per cycle on operand magnitudes, sign fix-up in a final cycle.
module seq_divider
    import riscv_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_out_q;
    logic [WIDTH-1:0] rem_out_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    // Most-negative maps onto itself, which reads correctly as 2^(WIDTH-1).
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor  : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (rem_q),
        .next_bit (dvd_q[WIDTH-1]),
        .divisor  (dsr_q),
        .rem_out  (step_rem),
        .q_bit    (step_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (flush) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            busy_q <= 1'b1;
                            if (divisor == '0) begin
                                state_q    <= S_DONE;
                                done_q     <= 1'b1;
                                dbz_q      <= 1'b1;
                                quot_out_q <= DIV0_QUOTIENT[WIDTH-1:0];
                                rem_out_q  <= dividend;
                            end else begin
                                state_q    <= S_CALC;
                                cnt_q      <= CW'(WIDTH - 1);
                                dvd_q      <= a_mag;
                                dsr_q      <= b_mag;
                                rem_q      <= '0;
                                neg_quot_q <= a_neg ^ b_neg;
                                neg_rem_q  <= a_neg;
                            end
                        end
                    end
                    S_CALC: begin
                        // dvd_q doubles as the quotient shift register.
                        rem_q <= step_rem;
                        dvd_q <= {dvd_q[WIDTH-2:0], step_qbit};
                        if (cnt_q == '0) begin
                            state_q <= S_SIGN;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_SIGN: begin
                        quot_out_q <= neg_quot_q ? -dvd_q : dvd_q;
                        rem_out_q  <= neg_rem_q  ? -rem_q : rem_q;
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quot_out_q;
    assign remainder   = rem_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed checks of seq_divider against an arithmetic model,
// with a done-driven scoreboard monitor.
module tb_seq_divider;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .flush       (flush),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: RISC-V division semantics with plain 64-bit arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        exp_t e;
        longint sa;
        longint sb_v;
        longint qq;
        longint rr;
        e.a = a; e.b = b; e.sgn = sgn; e.t0 = 0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 0;
        end else begin
            e.dbz = 1'b0; e.lat = W + 1;
            if (sgn) begin
                sa = longint'($signed(a));
                sb_v = longint'($signed(b));
                qq = sa / sb_v;
                rr = sa % sb_v;
            end else begin
                qq = longint'({32'd0, a}) / longint'({32'd0, b});
                rr = longint'({32'd0, a}) % longint'({32'd0, b});
            end
            e.q = qq[W-1:0];
            e.r = rr[W-1:0];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a result.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (div_by_zero && !done) begin
                errors++;
                $display("FAIL dbz_without_done: div_by_zero=1 done=0 at cycle %0d", cyc);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no pending op at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    check("latency", 32'(cyc - e.t0), 32'(e.lat));
                    last_q = e.q;
                    last_r = e.r;
                    $display("op %s %h / %h -> q=%h r=%h dbz=%0d lat=%0d",
                             e.sgn ? "DIV " : "DIVU", e.a, e.b, quotient, remainder,
                             div_by_zero, cyc - e.t0);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d ops still pending", sb.size());
            sb.delete();
        end
    endtask

    // Called at a negedge with the DUT idle; returns one negedge after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input bit expect_result);
        exp_t e;
        dividend = a;
        divisor = b;
        is_signed = sgn;
        start = 1'b1;
        if (expect_result) begin
            e = model(a, b, sgn);
            e.t0 = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        wait_idle();
        issue(a, b, sgn, 1'b1);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corners, issued back to back.
        run_op(32'd100, 32'd7, 1'b0);
        run_op(-32'sd7, 32'd2, 1'b1);
        run_op(32'd7, -32'sd2, 1'b1);
        run_op(32'd5, 32'd0, 1'b0);
        run_op(-32'sd5, 32'd0, 1'b1);
        run_op(MIN_NEG, 32'hFFFF_FFFF, 1'b1);
        run_op(MIN_NEG, 32'hFFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(32'd3, 32'd10, 1'b1);
        wait_done();
        wait_idle();

        // Flush mid-operation: no done, outputs keep the previous result.
        issue(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("busy_after_flush", {31'd0, busy}, 32'd0);
        check("quotient_held_flush", quotient, last_q);
        check("remainder_held_flush", remainder, last_r);
        repeat (40) @(negedge clk);
        run_op(32'd9, 32'd3, 1'b0);
        wait_done();
        wait_idle();

        // Flush together with start in IDLE drops the start.
        dividend = 32'd8; divisor = 32'd0; is_signed = 1'b0;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("busy_flush_start", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // Start while busy is ignored (a queued div-by-zero would show up as an extra done).
        run_op(32'd1000, 32'd10, 1'b0);
        repeat (5) @(negedge clk);
        dividend = 32'd77; divisor = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Start in the same cycle as done is ignored.
        wait_idle();
        issue(32'd50, 32'd5, 1'b0, 1'b1);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        dividend = 32'd9; divisor = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_after_done_start", {31'd0, busy}, 32'd0);
        check("quotient_held_idle", quotient, 32'd10);

        // Asynchronous reset mid-operation.
        run_op(32'd100, 32'd7, 1'b0);
        repeat (18) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_quotient", quotient, 32'd0);
        check("arst_remainder", remainder, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomised operations.
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = '1;
                3: ra = MIN_NEG;
                4: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end
        wait_done();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
